// File: rtl/demux16_pkg.sv
// Shared channel-count constants and channel index/mask types for the 1:16 router.
package demux16_pkg;
   localparam int N_CH  = 16;
   localparam int SEL_W = 4;

   typedef logic [SEL_W-1:0] ch_sel_t;
   typedef logic [N_CH-1:0]  ch_mask_t;
endpackage

// File: rtl/demux16_slot.sv
// One output slot of the router: a full flag plus a data register.
module demux16_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              drain,
   output logic              valid,
   output logic [DATA_W-1:0] data_out
);

   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A load in the drain cycle wins, so the slot stays full with no bubble.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (drain) full_d = 1'b0;
      if (load) begin
         full_d = 1'b1;
         data_d = data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign valid    = full_q;
   assign data_out = data_q;

endmodule

// File: rtl/demux16_router.sv
// 1:16 valid/ready routing demultiplexer with one-entry slot per channel.
// Define DEMUX16_STAT_EN to add the 16-bit xfer_cnt accepted-word counter.
module demux16_router
   import demux16_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  ch_sel_t                      in_sel,
   output ch_mask_t                     out_valid,
   input  ch_mask_t                     out_ready,
   output logic [N_CH-1:0][DATA_W-1:0]  out_data
`ifdef DEMUX16_STAT_EN
   ,
   output logic [15:0]                  xfer_cnt
`endif
);

   ch_mask_t load;
   logic     in_hs;

   // Ready only depends on the addressed slot, never on in_valid.
   assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
   assign in_hs    = in_valid && in_ready;

   always_comb begin
      load = '0;
      if (in_hs) load[in_sel] = 1'b1;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_slot
      demux16_slot #(.DATA_W(DATA_W)) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (load[k]),
         .data_in  (in_data),
         .drain    (out_ready[k]),
         .valid    (out_valid[k]),
         .data_out (out_data[k])
      );
   end

`ifdef DEMUX16_STAT_EN
   logic [15:0] cnt_q, cnt_d;

   // Free-running wrap at 16 bits.
   always_comb begin
      cnt_d = cnt_q;
      if (in_hs) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux16_router.sv
// Self-checking bench for demux16_router: per-channel queue model plus directed cases.
module tb_demux16_router;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [31:0]        in_data = '0;
   logic [3:0]         in_sel = '0;
   logic [15:0]        out_valid;
   logic [15:0]        out_ready = '0;
   logic [15:0][31:0]  out_data;
`ifdef DEMUX16_STAT_EN
   logic [15:0]        xfer_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mq [16][$];
   logic [15:0] mcnt = '0;
   logic        m_rdy;

   always #5 clk = ~clk;

   demux16_router #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX16_STAT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each channel is a FIFO of accepted-but-undelivered words.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) mq[k].delete();
         mcnt = '0;
      end else begin
         m_rdy = (mq[in_sel].size() == 0) || out_ready[in_sel];
         for (int k = 0; k < 16; k++)
            if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
         if (in_valid && m_rdy) begin
            mq[in_sel].push_back(in_data);
            mcnt = mcnt + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      logic [15:0] ev;
      for (int k = 0; k < 16; k++) begin
         ev[k] = (mq[k].size() != 0);
         chk("slot_depth", {31'd0, mq[k].size() > 1}, 32'd0);
      end
      chk("m_out_valid", {16'd0, out_valid}, {16'd0, ev});
      for (int k = 0; k < 16; k++) begin
         if (rst) chk("m_out_data_rst", out_data[k], 32'd0);
         else if (ev[k]) chk("m_out_data", out_data[k], mq[k][0]);
      end
      chk("m_in_ready", {31'd0, in_ready},
          {31'd0, (mq[in_sel].size() == 0) || out_ready[in_sel]});
`ifdef DEMUX16_STAT_EN
      chk("m_xfer_cnt", {16'd0, xfer_cnt}, {16'd0, mcnt});
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] got [$];
      logic        acc;
      logic [31:0] any_data;
      int          bound;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      any_data = '0;
      for (int k = 0; k < 16; k++) any_data |= out_data[k];
      chk("reset_out_valid", {16'd0, out_valid}, 32'd0);
      chk("reset_out_data", any_data, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Single word to channel 5
      in_valid = 1'b1; in_sel = 4'd5; in_data = 32'hDEAD_BEEF;
      #1 chk("single_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("single_valid", {16'd0, out_valid}, 32'h0000_0020);
      chk("single_data", out_data[5], 32'hDEAD_BEEF);
      out_ready[5] = 1'b1;
      step();
      out_ready = '0;
      chk("single_drained", {16'd0, out_valid}, 32'd0);

      // Backpressure on channel 3
      in_valid = 1'b1; in_sel = 4'd3; in_data = 32'h3333_0001;
      step();
      in_data = 32'h3333_0002;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         chk("bp_valid3", {31'd0, out_valid[3]}, 32'd1);
         chk("bp_data3_first", out_data[3], 32'h3333_0001);
         step();
      end
      out_ready[3] = 1'b1;
      #1 chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0; out_ready = '0;
      chk("bp_valid3_kept", {31'd0, out_valid[3]}, 32'd1);
      chk("bp_data3_second", out_data[3], 32'h3333_0002);
      out_ready[3] = 1'b1;
      step();
      out_ready = '0;

      // Stream 16 words, one per channel, no consumer
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_sel = 4'(k); in_data = 32'h100 + 32'(k);
         #1 chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         step();
      end
      in_valid = 1'b0;
      chk("stream_all_valid", {16'd0, out_valid}, 32'h0000_FFFF);
      for (int k = 0; k < 16; k++) chk("stream_data", out_data[k], 32'h100 + 32'(k));
      in_valid = 1'b1; in_sel = 4'($urandom_range(0, 15)); in_data = 32'hBAD0_0017;
      #1 chk("stream_17th_blocked", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0; out_ready = 16'hFFFF;
      step();
      out_ready = '0;
      chk("stream_drained", {16'd0, out_valid}, 32'd0);

      // Same-channel burst on channel 9
      out_ready[9] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_sel = 4'd9; in_data = 32'h900 + 32'(i);
         #1 chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
         if (i > 0) chk("burst_no_bubble", {31'd0, out_valid[9]}, 32'd1);
         if (out_valid[9]) got.push_back(out_data[9]);
         step();
      end
      in_valid = 1'b0;
      if (out_valid[9]) got.push_back(out_data[9]);
      step();
      out_ready = '0;
      chk("burst_count", got.size(), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("burst_order", got[i], 32'h900 + 32'(i));

      // Reset while slots 2 and 7 hold words
      in_valid = 1'b1; in_sel = 4'd2; in_data = 32'h2000_0001;
      step();
      in_sel = 4'd7; in_data = 32'h7000_0001;
      step();
      in_valid = 1'b0;
      chk("prerst_valid", {16'd0, out_valid}, 32'h0000_0084);
      #1 rst = 1'b1;
      #1 chk("async_rst_valid", {16'd0, out_valid}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      step();
      chk("postrst_valid", {16'd0, out_valid}, 32'd0);
      in_valid = 1'b1; in_sel = 4'd2; in_data = 32'h2000_0002;
      step();
      in_valid = 1'b0;
      chk("postrst_valid2", {16'd0, out_valid}, 32'h0000_0004);
      chk("postrst_data2", out_data[2], 32'h2000_0002);
      out_ready[2] = 1'b1;
      step();
      out_ready = '0;

      // Randomized traffic; producer holds its word until accepted
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 4'($urandom_range(0, 15));
            in_data  = $urandom;
         end
         out_ready = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      end
      in_valid = 1'b0;
      out_ready = 16'hFFFF;
      step();
      out_ready = '0;
      chk("random_drained", {16'd0, out_valid}, 32'd0);

`ifdef DEMUX16_STAT_EN
      out_ready = 16'hFFFF; in_valid = 1'b1; in_sel = 4'd0; in_data = 32'hC0FF_EE00;
      bound = 0;
      while (mcnt != 16'hFFFF && bound < 70000) begin
         step();
         bound++;
      end
      chk("wrap_bound", {31'd0, bound >= 70000}, 32'd0);
      chk("cnt_ffff", {16'd0, xfer_cnt}, 32'h0000_FFFF);
      step();
      in_valid = 1'b0;
      chk("cnt_wrap_zero", {16'd0, xfer_cnt}, 32'd0);
      step();
      out_ready = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
